// File: rtl/sync_lock_ctrl.sv
// Source-sync supervisor: measures line/frame timing and decides lock vs free-run for the output timing generator.
// Optional build macro SYNC_LOCK_STATS_EN adds loss_count and frame_count statistics outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// NOSYNC  | no usable source; test pattern, waiting for first vs_fall
// ACQUIRE | measuring frames, counting consecutive good ones
// LOCKED  | generator follows source; resync once per good frame
module sync_lock_ctrl #(
  parameter int H_MIN       = 700,
  parameter int H_MAX       = 900,
  parameter int H_TOL       = 2,
  parameter int V_MIN       = 200,
  parameter int V_MAX       = 600,
  parameter int LOCK_FRAMES = 4,
  parameter int LOSS_FRAMES = 2,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic        clk25,
  input  logic        reset_n,
  input  logic        HSYNC_in,
  input  logic        VSYNC_in,
  output logic        locked,
  output logic        freerun,
  output logic        resync_pulse,
  output logic [1:0]  pattern_sel,
  output logic [11:0] h_period,
  output logic [10:0] v_lines
`ifdef SYNC_LOCK_STATS_EN
  ,
  output logic [7:0]  loss_count,
  output logic [15:0] frame_count
`endif
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [11:0]     H_MIN_C   = 12'(H_MIN);
  localparam logic [11:0]     H_MAX_C   = 12'(H_MAX);
  localparam logic [11:0]     H_TOL_C   = 12'(H_TOL);
  localparam logic [10:0]     V_MIN_C   = 11'(V_MIN);
  localparam logic [10:0]     V_MAX_C   = 11'(V_MAX);
  localparam logic [3:0]      LOCK_LAST = 4'(LOCK_FRAMES - 1);
  localparam logic [3:0]      LOSS_LAST = 4'(LOSS_FRAMES - 1);

  localparam logic [1:0] PAT_PASS = 2'd0;
  localparam logic [1:0] PAT_NONE = 2'd1;
  localparam logic [1:0] PAT_ACQ  = 2'd2;

  typedef enum logic [1:0] {
    NOSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // synchroniser, edge detect and registered fall strobes
  logic hs_meta_q, hs_sync_q, hs_prev_q, hs_fall_q, hs_fall_d;
  logic vs_meta_q, vs_sync_q, vs_prev_q, vs_fall_q, vs_fall_d;

  // measurement
  logic [11:0]     h_cnt_q, h_cnt_d, h_cnt_inc, h_diff;
  logic [11:0]     h_period_q, h_period_d;
  logic [10:0]     v_cnt_q, v_cnt_d, v_cnt_inc, v_cap;
  logic [10:0]     v_lines_q, v_lines_d;
  logic [10:0]     v_ref_q, v_ref_d;
  logic            bad_frame_q, bad_frame_d;
  logic            line_ok, bad_line, frame_good;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout;

  // FSM and registered outputs
  state_t      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [3:0]  bad_cnt_q, bad_cnt_d;
  logic        resync_req_q, resync_req_d;
  logic        loss_evt, frame_evt;
  logic        locked_q, locked_d;
  logic        freerun_q, freerun_d;
  logic        resync_q, resync_d;
  logic [1:0]  pattern_q, pattern_d;

`ifdef SYNC_LOCK_STATS_EN
  logic [7:0]  loss_count_q, loss_count_d;
  logic [15:0] frame_count_q, frame_count_d;
`endif

  always_comb begin
    hs_fall_d = hs_prev_q & ~hs_sync_q;
    vs_fall_d = vs_prev_q & ~vs_sync_q;
  end

  always_comb begin
    h_cnt_inc  = (h_cnt_q == 12'hFFF) ? h_cnt_q : h_cnt_q + 12'd1;
    h_cnt_d    = h_cnt_inc;
    h_period_d = h_period_q;
    h_diff     = (h_cnt_inc >= h_period_q) ? (h_cnt_inc - h_period_q)
                                           : (h_period_q - h_cnt_inc);
    line_ok    = (h_cnt_inc >= H_MIN_C) && (h_cnt_inc <= H_MAX_C) && (h_diff <= H_TOL_C);
    bad_line   = hs_fall_q & ~line_ok;
    if (hs_fall_q) begin
      h_period_d = h_cnt_inc;
      h_cnt_d    = 12'd0;
    end
  end

  // A line whose hs_fall coincides with vs_fall belongs to the closing frame.
  always_comb begin
    v_cnt_inc   = (v_cnt_q == 11'h7FF) ? v_cnt_q : v_cnt_q + 11'd1;
    v_cap       = hs_fall_q ? v_cnt_inc : v_cnt_q;
    v_cnt_d     = v_cnt_q;
    v_lines_d   = v_lines_q;
    v_ref_d     = v_ref_q;
    bad_frame_d = bad_frame_q | bad_line;
    frame_good  = (v_cap >= V_MIN_C) && (v_cap <= V_MAX_C) &&
                  !(bad_frame_q || bad_line) && (v_cap == v_ref_q);
    if (vs_fall_q) begin
      v_lines_d   = v_cap;
      v_cnt_d     = 11'd0;
      bad_frame_d = 1'b0;
      // While locked the reference frame length is frozen, so one odd frame
      // does not poison the comparison for the frames that follow it.
      if (state_q != LOCKED || frame_good) begin
        v_ref_d = v_cap;
      end
    end else if (hs_fall_q) begin
      v_cnt_d = v_cnt_inc;
    end
  end

  always_comb begin
    timeout  = (to_cnt_q == TO_LAST);
    to_cnt_d = to_cnt_q;
    if (hs_fall_q) begin
      to_cnt_d = '0;
    end else if (!timeout) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    resync_req_d = 1'b0;
    loss_evt     = 1'b0;
    frame_evt    = 1'b0;
    case (state_q)
      NOSYNC: begin
        if (!timeout && vs_fall_q) begin
          state_d    = ACQUIRE;
          good_cnt_d = 4'd0;
        end
      end
      ACQUIRE: begin
        if (timeout) begin
          state_d = NOSYNC;
        end else if (vs_fall_q) begin
          if (!frame_good) begin
            good_cnt_d = 4'd0;
          end else if (good_cnt_q == LOCK_LAST) begin
            state_d      = LOCKED;
            bad_cnt_d    = 4'd0;
            resync_req_d = 1'b1;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_d  = NOSYNC;
          loss_evt = 1'b1;
        end else if (vs_fall_q) begin
          if (frame_good) begin
            bad_cnt_d    = 4'd0;
            resync_req_d = 1'b1;
            frame_evt    = 1'b1;
          end else if (bad_cnt_q == LOSS_LAST) begin
            state_d  = NOSYNC;
            loss_evt = 1'b1;
          end else begin
            bad_cnt_d = bad_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = NOSYNC;
    endcase
  end

  // Resync is gated on LOCKED so it lands on the same edge freerun drops.
  always_comb begin
    locked_d  = (state_q == LOCKED);
    freerun_d = (state_q != LOCKED);
    resync_d  = resync_req_q && (state_q == LOCKED);
    case (state_q)
      LOCKED:  pattern_d = PAT_PASS;
      ACQUIRE: pattern_d = PAT_ACQ;
      default: pattern_d = PAT_NONE;
    endcase
  end

`ifdef SYNC_LOCK_STATS_EN
  always_comb begin
    loss_count_d  = loss_count_q;
    frame_count_d = frame_count_q;
    if (loss_evt && loss_count_q != 8'hFF) loss_count_d = loss_count_q + 8'd1;
    if (frame_evt) frame_count_d = frame_count_q + 16'd1;
  end
`endif

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      hs_meta_q     <= 1'b1;
      hs_sync_q     <= 1'b1;
      hs_prev_q     <= 1'b1;
      hs_fall_q     <= 1'b0;
      vs_meta_q     <= 1'b1;
      vs_sync_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      vs_fall_q     <= 1'b0;
      h_cnt_q       <= 12'd0;
      h_period_q    <= 12'd0;
      v_cnt_q       <= 11'd0;
      v_lines_q     <= 11'd0;
      v_ref_q       <= 11'd0;
      bad_frame_q   <= 1'b0;
      to_cnt_q      <= '0;
      state_q       <= NOSYNC;
      good_cnt_q    <= 4'd0;
      bad_cnt_q     <= 4'd0;
      resync_req_q  <= 1'b0;
      locked_q      <= 1'b0;
      freerun_q     <= 1'b1;
      resync_q      <= 1'b0;
      pattern_q     <= PAT_NONE;
`ifdef SYNC_LOCK_STATS_EN
      loss_count_q  <= 8'd0;
      frame_count_q <= 16'd0;
`endif
    end else begin
      hs_meta_q     <= HSYNC_in;
      hs_sync_q     <= hs_meta_q;
      hs_prev_q     <= hs_sync_q;
      hs_fall_q     <= hs_fall_d;
      vs_meta_q     <= VSYNC_in;
      vs_sync_q     <= vs_meta_q;
      vs_prev_q     <= vs_sync_q;
      vs_fall_q     <= vs_fall_d;
      h_cnt_q       <= h_cnt_d;
      h_period_q    <= h_period_d;
      v_cnt_q       <= v_cnt_d;
      v_lines_q     <= v_lines_d;
      v_ref_q       <= v_ref_d;
      bad_frame_q   <= bad_frame_d;
      to_cnt_q      <= to_cnt_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      resync_req_q  <= resync_req_d;
      locked_q      <= locked_d;
      freerun_q     <= freerun_d;
      resync_q      <= resync_d;
      pattern_q     <= pattern_d;
`ifdef SYNC_LOCK_STATS_EN
      loss_count_q  <= loss_count_d;
      frame_count_q <= frame_count_d;
`endif
    end
  end

  assign locked       = locked_q;
  assign freerun      = freerun_q;
  assign resync_pulse = resync_q;
  assign pattern_sel  = pattern_q;
  assign h_period     = h_period_q;
  assign v_lines      = v_lines_q;
`ifdef SYNC_LOCK_STATS_EN
  assign loss_count   = loss_count_q;
  assign frame_count  = frame_count_q;
`endif

endmodule
